// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg: ALU opcode type and constants shared by the ALU datapath and its arbiter
package alu_share_arb_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
    localparam int unsigned N_REQ = 2;
endpackage

// File: rtl/alu_share_arb_alu32.sv
// alu32: combinational 32-bit ALU; opcodes outside ADD..SLTU yield 0 and flag illegal
module alu32
    import alu_share_arb_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        illegal
);
    logic [4:0] sh;
    assign sh = b[4:0];
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << sh;
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = $unsigned($signed(a) >>> sh);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one ALU through a round-robin/fixed-priority arbiter,
// each with a one-entry registered response buffer that can drain and refill in the same cycle
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  alu_op_t     req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  alu_op_t     req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp0_data,
    output logic [31:0] rsp1_data,
    output logic [1:0]  rsp_err,
    output logic [31:0] op_count
);
    logic [1:0]  elig, grant, valid_q, err_q;
    logic [31:0] data_q [N_REQ];
    logic [31:0] cnt_q, result;
    logic        ptr_q, illegal;
    alu_op_t     op_sel;
    assign elig = req_valid & (~valid_q | rsp_ready);
    // The pointer only matters when both are eligible; a lone eligible requester always wins
    always_comb grant = (&elig) ? ((RR_EN && ptr_q) ? 2'b10 : 2'b01) : elig;
    assign req_ready = rst_n ? grant : 2'b00;
    assign op_sel = grant[1] ? req1_op : req0_op;
    alu32 u_alu (
        .op      (op_sel),
        .a       (grant[1] ? req1_a : req0_a),
        .b       (grant[1] ? req1_b : req0_b),
        .result  (result),
        .illegal (illegal)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 2'b00;
            err_q     <= 2'b00;
            data_q[0] <= '0;
            data_q[1] <= '0;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    valid_q[i] <= 1'b1;
                    data_q[i]  <= result;
                    err_q[i]   <= illegal;
                end else if (rsp_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (|grant) begin
                cnt_q <= cnt_q + 32'd1;
                if (RR_EN) ptr_q <= ~grant[1];
            end
        end
    end
    assign rsp_valid = valid_q;
    assign rsp_err   = err_q & valid_q;
    assign rsp0_data = data_q[0];
    assign rsp1_data = data_q[1];
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of arbitration, buffering, ALU results, reset and counter wrap
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  req_valid = '0, rsp_ready = '0;
    alu_op_t     op0 = ALU_ADD, op1 = ALU_ADD;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]  req_ready, rsp_valid, rsp_err;
    logic [31:0] d0, d1, op_count;
    logic [1:0]  fp_req_ready, fp_rsp_valid, fp_rsp_err;
    logic [31:0] fp_d0, fp_d1, fp_op_count;
    int pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(op0), .req0_a(a0), .req0_b(b0), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp0_data(d0), .rsp1_data(d1),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    alu_share_arb #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
        .req0_op(op0), .req0_a(a0), .req0_b(b0), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp0_data(fp_d0), .rsp1_data(fp_d1),
        .rsp_err(fp_rsp_err), .op_count(fp_op_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_err !== 2'b00) $display("FAIL reset_rsp_err: got %b want 00", rsp_err); else pass_cnt++;
        total_cnt++; if ({d0, d1} !== 64'h0) $display("FAIL reset_data: got %h %h want 0 0", d0, d1); else pass_cnt++;
        total_cnt++; if (op_count !== 32'h0) $display("FAIL reset_op_count: got %h want 0", op_count); else pass_cnt++;
    endtask

    task automatic test_or();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b11; op0 = ALU_OR; a0 = 32'h0F0F0000; b0 = 32'h000000FF;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL or_req_ready: got %b want 01", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL or_latency: got %b want 00", rsp_valid); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL or_rsp_valid: got %b want 01", rsp_valid); else pass_cnt++;
        total_cnt++; if (d0 !== 32'h0F0F00FF) $display("FAIL or_data: got %h want 0f0f00ff", d0); else pass_cnt++;
        total_cnt++; if (op_count !== 32'd1) $display("FAIL or_op_count: got %0d want 1", op_count); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL or_drain: got %b want 00", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b11;
        op0 = ALU_ADD; a0 = 32'd5; b0 = 32'd3; op1 = ALU_SUB; a1 = 32'd10; b1 = 32'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++; if (req_ready !== exp_g[k]) $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_g[k]); else pass_cnt++;
            total_cnt++; if (fp_req_ready !== 2'b01) $display("FAIL fp_grant%0d: got %b want 01", k, fp_req_ready); else pass_cnt++;
            @(negedge clk);
        end
        req_valid = 2'b00;
        total_cnt++; if (op_count !== 32'd4) $display("FAIL rr_op_count: got %0d want 4", op_count); else pass_cnt++;
        total_cnt++; if ({d0, d1} !== {32'd8, 32'd7}) $display("FAIL rr_data: got %h %h want 8 7", d0, d1); else pass_cnt++;
        total_cnt++; if (fp_op_count !== 32'd4) $display("FAIL fp_op_count: got %0d want 4", fp_op_count); else pass_cnt++;
        total_cnt++; if ({fp_rsp_valid, fp_d1} !== {2'b01, 32'd0}) $display("FAIL fp_state: got %b %h want 01 0", fp_rsp_valid, fp_d1); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; rsp_ready = 2'b00; op0 = ALU_ADD; a0 = 32'h100; b0 = 32'h23;
        @(posedge clk); #1;
        total_cnt++; if ({rsp_valid, d0} !== {2'b01, 32'h123}) $display("FAIL bp_fill: got %b %h want 01 123", rsp_valid, d0); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 2'b11; rsp_ready = 2'b10; a0 = 32'hDEAD0000 + k;
            op1 = ALU_ADD; a1 = k; b1 = 32'h10;
            #1;
            total_cnt++; if (req_ready !== 2'b10) $display("FAIL bp_grant%0d: got %b want 10", k, req_ready); else pass_cnt++;
            total_cnt++; if (fp_req_ready !== 2'b10) $display("FAIL bp_fp_grant%0d: got %b want 10", k, fp_req_ready); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (d1 !== 32'h10 + k) $display("FAIL bp_d1_%0d: got %h want %h", k, d1, 32'h10 + k); else pass_cnt++;
            total_cnt++; if ({rsp_valid, d0} !== {2'b11, 32'h123}) $display("FAIL bp_hold%0d: got %b %h want 11 123", k, rsp_valid, d0); else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b11;
        @(posedge clk); #1;
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL bp_drain: got %b want 00", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        req_valid = 2'b10; rsp_ready = 2'b11; op1 = alu_op_t'(4'd12); a1 = 32'h123; b1 = 32'h456;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL ill_grant: got %b want 10", req_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if ({rsp_valid, rsp_err, d1} !== {2'b10, 2'b10, 32'h0}) $display("FAIL ill_rsp: got %b %b %h want 10 10 0", rsp_valid, rsp_err, d1); else pass_cnt++;
        @(negedge clk);
        op1 = ALU_SRA; a1 = 32'h80000000; b1 = 32'd4;
        @(posedge clk); #1;
        total_cnt++; if ({rsp_valid, rsp_err, d1} !== {2'b10, 2'b00, 32'hF8000000}) $display("FAIL sra_rsp: got %b %b %h want 10 00 f8000000", rsp_valid, rsp_err, d1); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_alu_ops();
        alu_op_t     t_op [8] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU};
        logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] t_b  [8] = '{32'h1, 32'h1, 32'hFF00FF00, 32'hFF00FF00, 32'h24, 32'd31, 32'h1, 32'h1};
        logic [31:0] t_e  [8] = '{32'h0, 32'hFFFFFFFF, 32'hF000F000, 32'h0FF00FF0, 32'h10, 32'h1, 32'h1, 32'h0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = 2'b01; rsp_ready = 2'b11; op0 = t_op[k]; a0 = t_a[k]; b0 = t_b[k];
            @(posedge clk); #1;
            total_cnt++; if ({rsp_err[0], d0} !== {1'b0, t_e[k]}) $display("FAIL alu_%0d: got err=%b %h want err=0 %h", k, rsp_err[0], d0, t_e[k]); else pass_cnt++;
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b00; op0 = ALU_ADD; a0 = 32'd1; b0 = 32'd1; op1 = ALU_ADD; a1 = 32'd2; b1 = 32'd2;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if ({rsp_valid, op_count} !== {2'b11, 32'd2}) $display("FAIL mid_full: got %b %0d want 11 2", rsp_valid, op_count); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({rsp_valid, op_count} !== {2'b00, 32'd0}) $display("FAIL mid_async: got %b %0d want 00 0", rsp_valid, op_count); else pass_cnt++;
        total_cnt++; if ({req_ready, d0, d1} !== {2'b00, 64'h0}) $display("FAIL mid_clear: got %b %h %h want 00 0 0", req_ready, d0, d1); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 2'b11;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_first_grant: got %b want 01", req_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if ({rsp_valid, op_count} !== {2'b01, 32'd1}) $display("FAIL mid_first_accept: got %b %0d want 01 1", rsp_valid, op_count); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1 release dut.cnt_q;
        #1;
        total_cnt++; if (op_count !== 32'hFFFFFFFF) $display("FAIL wrap_preload: got %h want ffffffff", op_count); else pass_cnt++;
        req_valid = 2'b10; rsp_ready = 2'b11; op1 = ALU_ADD; a1 = 32'd0; b1 = 32'd0;
        @(posedge clk); #1;
        total_cnt++; if (op_count !== 32'h0) $display("FAIL wrap_zero: got %h want 0", op_count); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_or();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_alu_ops();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
